// File: rtl/bmem_arb_pkg.sv
// rtl/bmem_arb_pkg.sv - shared types and constants for the bmem arbiter
package bmem_arb_pkg;

  localparam int ADDR_W      = 32;
  localparam int BEAT_W      = 64;
  localparam int LINE_BITS   = 256;
  localparam int LINE_OFFSET = 5;
  localparam int BEAT_IDX_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic                  issued;
    logic                  is_read;
    logic [ADDR_W-1:0]     line_addr;
    logic [BEAT_IDX_W-1:0] beat_cnt;
    logic [LINE_BITS-1:0]  line_buf;
  } port_state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_arbiter_rr.sv
// rtl/bmem_arbiter_rr.sv - round-robin grant with a pointer that moves past each winner
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gi;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    gi    = ptr_q;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gi         = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (int'(gi) == NUM_PORTS - 1) ? '0 : PW'(int'(gi) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - multiplexes cacheline reads/writes onto one bmem port
// and reassembles out-of-order read bursts by returning address.
module bmem_arbiter
  import bmem_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int BEAT_WIDTH = BEAT_W,
  parameter int BURST_LEN  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][LINE_BITS-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [NUM_PORTS-1:0][LINE_BITS-1:0]  req_rdata,
  output logic [ADDR_WIDTH-1:0]                bmem_addr,
  output logic                                 bmem_read,
  output logic                                 bmem_write,
  output logic [BEAT_WIDTH-1:0]                bmem_wdata,
  input  logic                                 bmem_ready,
  input  logic [ADDR_WIDTH-1:0]                bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]                bmem_rdata,
  input  logic                                 bmem_rvalid,
  output logic                                 err
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  fsm_state_t                          state_q, state_d;
  port_state_t                         ps_q [NUM_PORTS];
  port_state_t                         ps_d [NUM_PORTS];
  logic [PW-1:0]                       cur_q, cur_d;
  logic [BEAT_IDX_W-1:0]               wbeat_q, wbeat_d;
  logic                                rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;
  logic [BEAT_WIDTH-1:0]               wdata_q, wdata_d;
  logic [NUM_PORTS-1:0]                resp_q, resp_d;
  logic [NUM_PORTS-1:0][LINE_BITS-1:0] rdata_q, rdata_d;
  logic                                err_q, err_d;

  logic [NUM_PORTS-1:0] pend, arb_req, gnt;
  logic [PW-1:0]        gidx, hidx;
  logic                 hit;
  logic [LINE_BITS-1:0] line_nxt;

  // A port waiting on a line that is already in flight as a read must wait,
  // otherwise two identical raddr bursts could not be told apart.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      pend[p] = (req_read[p] | req_write[p]) & ~ps_q[p].issued;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (ps_q[q].issued && ps_q[q].is_read &&
            ps_q[q].line_addr == line_align(req_addr[p])) begin
          pend[p] = 1'b0;
        end
      end
    end
    arb_req = (state_q == IDLE && !rd_q && !wr_q) ? pend : '0;
  end

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk     (clk),
    .rst_n   (rst),
    .req     (arb_req),
    .advance (|gnt),
    .grant   (gnt)
  );

  always_comb begin
    gidx = '0;
    hit  = 1'b0;
    hidx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) gidx = PW'(p);
      if (ps_q[p].issued && ps_q[p].is_read && !resp_q[p] &&
          ps_q[p].line_addr == line_align(bmem_raddr)) begin
        hit  = 1'b1;
        hidx = PW'(p);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    cur_d    = cur_q;
    wbeat_d  = wbeat_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    resp_d   = '0;
    rdata_d  = rdata_q;
    err_d    = err_q | (|(req_read & req_write));
    line_nxt = '0;

    // Issued flag drops during the response cycle so the port re-arbitrates one cycle later.
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (resp_q[p]) ps_d[p].issued = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rd_q) begin
          if (bmem_ready) begin
            rd_d                   = 1'b0;
            ps_d[cur_q].issued     = 1'b1;
            ps_d[cur_q].is_read    = 1'b1;
            ps_d[cur_q].line_addr  = addr_q;
            ps_d[cur_q].beat_cnt   = '0;
          end
        end else if (|gnt) begin
          cur_d  = gidx;
          addr_d = line_align(req_addr[gidx]);
          if (req_write[gidx]) begin
            state_d              = WRITE;
            wr_d                 = 1'b1;
            wbeat_d              = '0;
            wdata_d              = req_wdata[gidx][BEAT_WIDTH-1:0];
            ps_d[gidx].issued    = 1'b1;
            ps_d[gidx].is_read   = 1'b0;
          end else begin
            rd_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (bmem_ready) begin
          if (wbeat_q == BEAT_IDX_W'(BURST_LEN - 1)) begin
            state_d       = IDLE;
            wr_d          = 1'b0;
            resp_d[cur_q] = 1'b1;
          end else begin
            wbeat_d = wbeat_q + 1'b1;
            wdata_d = req_wdata[cur_q][(int'(wbeat_q) + 1) * BEAT_WIDTH +: BEAT_WIDTH];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bmem_rvalid) begin
      if (hit) begin
        line_nxt = ps_q[hidx].line_buf;
        line_nxt[int'(ps_q[hidx].beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
        ps_d[hidx].line_buf = line_nxt;
        ps_d[hidx].beat_cnt = ps_q[hidx].beat_cnt + 1'b1;
        if (ps_q[hidx].beat_cnt == BEAT_IDX_W'(BURST_LEN - 1)) begin
          resp_d[hidx]  = 1'b1;
          rdata_d[hidx] = line_nxt;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int p = 0; p < NUM_PORTS; p++) ps_q[p] <= '0;
      cur_q   <= '0;
      wbeat_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      cur_q   <= cur_d;
      wbeat_q <= wbeat_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_resp   = resp_q;
  assign req_rdata  = rdata_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = rd_q;
  assign bmem_write = wr_q;
  assign bmem_wdata = wdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - scoreboard bench for bmem_arbiter
module tb_bmem_arbiter;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0][31:0]  req_addr;
  logic [1:0]        req_read;
  logic [1:0]        req_write;
  logic [1:0][255:0] req_wdata;
  logic [1:0]        req_resp;
  logic [1:0][255:0] req_rdata;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [63:0]       bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [63:0]       bmem_rdata;
  logic              bmem_rvalid;
  logic              err;

  bmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_addr    (req_addr),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_resp    (req_resp),
    .req_rdata   (req_rdata),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_accepts = 0;
  logic [256:0] exp0 [$];
  logic [256:0] exp1 [$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] ra, input logic [63:0] d);
    bmem_raddr  = ra;
    bmem_rdata  = d;
    bmem_rvalid = 1'b1;
    tick();
    bmem_rvalid = 1'b0;
  endtask

  task automatic send_line(input logic [31:0] ra, input logic [255:0] line);
    for (int k = 0; k < 4; k++) send_beat(ra, line[k*64 +: 64]);
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    while (!bmem_read && n < 20) begin
      tick();
      n++;
    end
    check(tag, bmem_read, 1'b1);
  endtask

  // Response scoreboard: every req_resp pulse must match a queued expectation.
  always @(negedge clk) begin
    logic [256:0] e;
    if (rst) begin
      if (bmem_read && bmem_ready) rd_accepts++;
      if (req_resp[0]) begin
        if (exp0.size() == 0) check("resp0_unexpected", req_resp[0], 1'b0);
        else begin
          e = exp0.pop_front();
          if (!e[256]) check("rdata0", req_rdata[0], e[255:0]);
        end
      end
      if (req_resp[1]) begin
        if (exp1.size() == 0) check("resp1_unexpected", req_resp[1], 1'b0);
        else begin
          e = exp1.pop_front();
          if (!e[256]) check("rdata1", req_rdata[1], e[255:0]);
        end
      end
    end
  end

  logic [255:0] la, lb, lc, ld, lw, lw2, la1;
  int pat [6] = '{1, 0, 1, 1, 0, 1};
  int k;
  int rd_start;

  initial begin
    la  = {64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    lb  = {64'hB0B0_0000_0000_0003, 64'hB0B0_0000_0000_0002, 64'hB0B0_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    lc  = {64'hC0C0_1111_0000_0003, 64'hC0C0_1111_0000_0002, 64'hC0C0_1111_0000_0001, 64'hC0C0_1111_0000_0000};
    ld  = {64'hD0D0_2222_0000_0003, 64'hD0D0_2222_0000_0002, 64'hD0D0_2222_0000_0001, 64'hD0D0_2222_0000_0000};
    lw  = {64'h5757_0000_0000_0003, 64'h5757_0000_0000_0002, 64'h5757_0000_0000_0001, 64'h5757_0000_0000_0000};
    lw2 = {64'h6868_0000_0000_0003, 64'h6868_0000_0000_0002, 64'h6868_0000_0000_0001, 64'h6868_0000_0000_0000};
    la1 = {64'h1111_AAAA_0000_00A3, 64'h1111_AAAA_0000_00A2, 64'h1111_AAAA_0000_00A1, 64'h1111_AAAA_0000_00A0};
    req_addr = '0; req_read = '0; req_write = '0; req_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    tick(); tick();
    check("rst_read", bmem_read, 1'b0);
    check("rst_write", bmem_write, 1'b0);
    check("rst_addr", bmem_addr, 32'h0);
    check("rst_resp", req_resp, 2'b00);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    tick();

    // Both ports read, memory answers interleaved with port 1's line finishing first.
    req_addr[0] = 32'h100; req_addr[1] = 32'h200; req_read = 2'b11;
    exp0.push_back({1'b0, la}); exp1.push_back({1'b0, lb});
    tick();
    check("t2_rd0", bmem_read, 1'b1);
    check("t2_addr0", bmem_addr, 32'h100);
    tick();
    check("t2_rd0_done", bmem_read, 1'b0);
    tick();
    check("t2_rd1", bmem_read, 1'b1);
    check("t2_addr1", bmem_addr, 32'h200);
    tick();
    send_beat(32'h200, lb[63:0]);    send_beat(32'h100, la[63:0]);
    send_beat(32'h200, lb[127:64]);  send_beat(32'h100, la[127:64]);
    send_beat(32'h200, lb[191:128]); send_beat(32'h200, lb[255:192]);
    check("t2_resp_p1_first", req_resp, 2'b10);
    req_read[1] = 1'b0;
    send_beat(32'h100, la[191:128]); send_beat(32'h100, la[255:192]);
    check("t2_resp_p0", req_resp, 2'b01);
    req_read[0] = 1'b0;
    tick();

    // Port 1 write with a stalling memory.
    req_addr[1] = 32'h40; req_wdata[1] = lw; req_write[1] = 1'b1; bmem_ready = 1'b0;
    exp1.push_back({1'b1, 256'h0});
    tick();
    check("t3_write", bmem_write, 1'b1);
    check("t3_addr", bmem_addr, 32'h40);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bmem_ready = pat[i][0];
      check("t3_wdata", bmem_wdata, lw[k*64 +: 64]);
      check("t3_rw_excl", bmem_read, 1'b0);
      if (pat[i] != 0) k++;
      tick();
    end
    check("t3_resp", req_resp, 2'b10);
    check("t3_write_done", bmem_write, 1'b0);
    req_write[1] = 1'b0; bmem_ready = 1'b1;
    tick();

    // Same line requested by both ports: second read withheld until the first completes.
    rd_start = rd_accepts;
    req_addr[0] = 32'h300; req_addr[1] = 32'h300; req_read = 2'b11;
    exp0.push_back({1'b0, lc}); exp1.push_back({1'b0, ld});
    tick();
    check("t4_rd0", bmem_read, 1'b1);
    check("t4_addr0", bmem_addr, 32'h300);
    tick(); tick(); tick();
    check("t4_hazard_hold", bmem_read, 1'b0);
    send_line(32'h300, lc);
    check("t4_resp0", req_resp, 2'b01);
    req_read[0] = 1'b0;
    wait_read("t4_rd1_timeout");
    check("t4_addr1", bmem_addr, 32'h300);
    tick();
    send_line(32'h300, ld);
    check("t4_resp1", req_resp, 2'b10);
    req_read[1] = 1'b0;
    tick();
    check("t4_two_reads", 32'(rd_accepts - rd_start), 32'd2);
    check("t4_err", err, 1'b0);

    // Orphan beat.
    send_beat(32'hDEAD_0000, 64'h1234);
    check("t5_err", err, 1'b1);
    check("t5_resp", req_resp, 2'b00);
    tick(); tick(); tick();
    check("t5_err_sticky", err, 1'b1);

    // Reset in the middle of a write burst, then a normal read.
    req_addr[0] = 32'h80; req_wdata[0] = lw2; req_write[0] = 1'b1;
    tick();
    check("t6_write", bmem_write, 1'b1);
    tick();
    check("t6_beat1", bmem_wdata, lw2[127:64]);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t6_rst_write", bmem_write, 1'b0);
    check("t6_rst_read", bmem_read, 1'b0);
    check("t6_rst_addr", bmem_addr, 32'h0);
    check("t6_rst_wdata", bmem_wdata, 64'h0);
    check("t6_rst_resp", req_resp, 2'b00);
    check("t6_rst_rdata0", req_rdata[0], 256'h0);
    check("t6_rst_err", err, 1'b0);
    req_write = '0;
    tick(); tick();
    rst = 1'b1;
    tick();

    req_addr[0] = 32'h0000_1024; req_read[0] = 1'b1;
    exp0.push_back({1'b0, la1});
    tick();
    check("t1_read", bmem_read, 1'b1);
    check("t1_addr", bmem_addr, 32'h0000_1020);
    tick();
    check("t1_read_one_cycle", bmem_read, 1'b0);
    send_line(32'h0000_1020, la1);
    check("t1_resp", req_resp, 2'b01);
    req_read[0] = 1'b0;
    tick();
    check("t1_resp_pulse", req_resp, 2'b00);
    check("t1_rdata_held", req_rdata[0], la1);
    check("t6_no_orphan_resp", err, 1'b0);

    tick();
    check("sb0_empty", 32'(exp0.size()), 32'd0);
    check("sb1_empty", 32'(exp1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
